// File: rtl/rete_mnist_axi4_slave_mem.sv
// AXI4 INCR burst slave over a word-addressed register array; one burst at a time, write/read round-robin.
// AW/AR accepted one cycle after valid is seen in IDLE, then one beat per cycle; B and R hold until BREADY/RREADY.
module rete_mnist_axi4_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam int NB    = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, AW_ACK, WDATA, WRESP, AR_ACK, RDATA} state_t;

  state_t                          state, state_nxt;
  logic [IW-1:0]                   idx, idx_inc;
  logic [7:0]                      len, cnt;
  logic [C_S_AXI_ID_WIDTH-1:0]     id;
  logic                            err_cfg, err_proto, last_wr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0]   mem [DEPTH];
  logic                            w_beat, r_beat, final_beat;
  logic                            unused_addr;

  assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign idx_inc     = idx + 1'b1;
  assign final_beat  = (cnt == len);
  assign w_beat      = (state == WDATA) && S_AXI_WVALID;
  assign r_beat      = (state == RDATA) && S_AXI_RREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // last_wr=1 means the previous burst was a write, so a contending read wins
        if (S_AXI_AWVALID && (!S_AXI_ARVALID || !last_wr)) state_nxt = AW_ACK;
        else if (S_AXI_ARVALID)                             state_nxt = AR_ACK;
      end
      AW_ACK:  state_nxt = WDATA;
      WDATA:   if (w_beat && final_beat) state_nxt = WRESP;
      WRESP:   if (S_AXI_BREADY) state_nxt = IDLE;
      AR_ACK:  state_nxt = RDATA;
      RDATA:   if (r_beat && final_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      id        <= '0;
      err_cfg   <= 1'b0;
      err_proto <= 1'b0;
      last_wr   <= 1'b0;
      rdata     <= '0;
    end else begin
      case (state)
        AW_ACK: begin
          id        <= S_AXI_AWID;
          idx       <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          len       <= S_AXI_AWLEN;
          cnt       <= '0;
          err_cfg   <= (S_AXI_AWSIZE != 3'd2) || (S_AXI_AWBURST != 2'b01);
          err_proto <= 1'b0;
        end
        WDATA: begin
          if (w_beat) begin
            idx <= idx_inc;
            cnt <= cnt + 8'd1;
            // burst length comes from AWLEN; WLAST is only cross-checked
            if (S_AXI_WLAST != final_beat) err_proto <= 1'b1;
          end
        end
        WRESP: begin
          if (S_AXI_BREADY) last_wr <= 1'b1;
        end
        AR_ACK: begin
          id        <= S_AXI_ARID;
          idx       <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          len       <= S_AXI_ARLEN;
          cnt       <= '0;
          err_cfg   <= (S_AXI_ARSIZE != 3'd2) || (S_AXI_ARBURST != 2'b01);
          err_proto <= 1'b0;
          if ((S_AXI_ARSIZE != 3'd2) || (S_AXI_ARBURST != 2'b01)) rdata <= '0;
          else rdata <= mem[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
        end
        RDATA: begin
          if (r_beat) begin
            if (final_beat) begin
              last_wr <= 1'b0;
            end else begin
              idx   <= idx_inc;
              cnt   <= cnt + 8'd1;
              rdata <= err_cfg ? '0 : mem[idx_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Contents deliberately survive reset
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_beat && !err_cfg) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = (state == AW_ACK);
  assign S_AXI_WREADY  = (state == WDATA);
  assign S_AXI_BVALID  = (state == WRESP);
  assign S_AXI_BID     = (state == WRESP) ? id : '0;
  assign S_AXI_BRESP   = ((state == WRESP) && (err_cfg || err_proto)) ? 2'b10 : 2'b00;
  assign S_AXI_ARREADY = (state == AR_ACK);
  assign S_AXI_RVALID  = (state == RDATA);
  assign S_AXI_RID     = (state == RDATA) ? id : '0;
  assign S_AXI_RRESP   = ((state == RDATA) && err_cfg) ? 2'b10 : 2'b00;
  assign S_AXI_RLAST   = (state == RDATA) && final_beat;
  assign S_AXI_RDATA   = rdata;

endmodule

// File: tb/tb_rete_mnist_axi4_slave_mem.sv
// Bench for rete_mnist_axi4_slave_mem: directed scenarios plus randomized bursts against a word-array model.
module tb_rete_mnist_axi4_slave_mem;
  localparam int TMO = 40;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [0:0]  S_AXI_AWID = '0;
  logic [7:0]  S_AXI_AWADDR = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [2:0]  S_AXI_AWSIZE = '0;
  logic [1:0]  S_AXI_AWBURST = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [0:0]  S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [0:0]  S_AXI_ARID = '0;
  logic [7:0]  S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = '0;
  logic [1:0]  S_AXI_ARBURST = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [0:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  rete_mnist_axi4_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [64];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  logic [31:0] rd_dat [256];
  logic        rd_last [256];
  logic [1:0]  rd_resp [256];
  logic        rd_id [256];
  int          aw_wait, ar_wait, r_wait0, b_wait;
  logic [1:0]  b_resp;
  logic        b_id;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: handshake not seen within %0d cycles", name, TMO);
  endtask

  task automatic rand_data(input int len);
    for (int i = 0; i <= len; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'hF;
    end
  endtask

  // Model: INCR bursts of 32-bit words wrapping over 64 words; bad size/burst writes nothing
  task automatic model_write(input logic [7:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst);
    if (size != 3'd2 || burst != 2'b01) return;
    for (int i = 0; i <= len; i++) begin
      int w;
      w = ((int'(addr) / 4) + i) % 64;
      for (int b = 0; b < 4; b++)
        if (wstb[i][b]) model_mem[w][8*b +: 8] = wdat[i][8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [7:0] addr, input int i, input logic err);
    if (err) return 32'h0;
    return model_mem[((int'(addr) / 4) + i) % 64];
  endfunction

  task automatic aw_handshake();
    int n = 0;
    while (!S_AXI_AWREADY && n < TMO) begin tick(); n++; end
    aw_wait = n;
    if (!S_AXI_AWREADY) timeout_fail("awready");
    tick();
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic w_beats(input int len, input int bad_beat);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      S_AXI_WVALID = 1'b1;
      S_AXI_WDATA  = wdat[i];
      S_AXI_WSTRB  = wstb[i];
      S_AXI_WLAST  = (i == len) ^ (i == bad_beat);
      while (!S_AXI_WREADY && n < TMO) begin tick(); n++; end
      if (!S_AXI_WREADY) timeout_fail("wready");
      tick();
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
  endtask

  task automatic b_handshake();
    int n = 0;
    S_AXI_BREADY = 1'b1;
    while (!S_AXI_BVALID && n < TMO) begin tick(); n++; end
    b_wait = n;
    b_resp = S_AXI_BRESP;
    b_id   = S_AXI_BID;
    if (!S_AXI_BVALID) timeout_fail("bvalid");
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic set_aw(input logic [7:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input logic id);
    S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWSIZE = size;
    S_AXI_AWBURST = burst; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
  endtask

  task automatic set_ar(input logic [7:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input logic id);
    S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARSIZE = size;
    S_AXI_ARBURST = burst; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input int bad_beat);
    set_aw(addr, len, size, burst, id);
    aw_handshake();
    w_beats(len, bad_beat);
    b_handshake();
  endtask

  task automatic ar_handshake();
    int n = 0;
    while (!S_AXI_ARREADY && n < TMO) begin tick(); n++; end
    ar_wait = n;
    if (!S_AXI_ARREADY) timeout_fail("arready");
    tick();
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic r_beats(input int len);
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      while (!S_AXI_RVALID && n < TMO) begin tick(); n++; end
      if (i == 0) r_wait0 = n;
      if (!S_AXI_RVALID) timeout_fail("rvalid");
      rd_dat[i] = S_AXI_RDATA; rd_last[i] = S_AXI_RLAST;
      rd_resp[i] = S_AXI_RRESP; rd_id[i] = S_AXI_RID;
      tick();
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id);
    set_ar(addr, len, size, burst, id);
    ar_handshake();
    r_beats(len);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b, want 000000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST});
    end
    vectors++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_resp_id: got %b, want 000000", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID});
    end
    vectors++;
    if (S_AXI_RDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h, want 00000000", S_AXI_RDATA);
    end
    repeat (3) tick();
    ARESET = 1'b0;
    tick();
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 4'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b, want 0000",
               {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
  endtask

  task automatic test_fill();
    rand_data(63);
    axi_write(8'h00, 63, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'h00, 63, 3'd2, 2'b01);
    vectors++;
    if (b_resp !== 2'b00) begin miscompares++; $display("FAIL fill_bresp: got %b, want 00", b_resp); end
  endtask

  task automatic test_reset_mid_write();
    rand_data(7);
    set_aw(8'h40, 7, 3'd2, 2'b01, 1'b0);
    aw_handshake();
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      S_AXI_WVALID = 1'b1; S_AXI_WDATA = wdat[i]; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0;
      while (!S_AXI_WREADY && n < TMO) begin tick(); n++; end
      if (!S_AXI_WREADY) timeout_fail("mid_wready");
      tick();
    end
    model_write(8'h40, 2, 3'd2, 2'b01);
    ARESET = 1'b1;
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST,
         S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID} !== 12'b0 || S_AXI_RDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_burst_reset: outputs not all zero (wready=%b rdata=%h), want all 0",
               S_AXI_WREADY, S_AXI_RDATA);
    end
    S_AXI_WVALID = 1'b0;
    tick(); tick();
    ARESET = 1'b0;
    tick();
    rand_data(1);
    axi_write(8'h60, 1, 3'd2, 2'b01, 1'b1, -1);
    model_write(8'h60, 1, 3'd2, 2'b01);
    vectors++;
    if (b_resp !== 2'b00 || b_id !== 1'b1) begin
      miscompares++;
      $display("FAIL fresh_write_after_reset: bresp=%b bid=%b, want 00/1", b_resp, b_id);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    axi_write(8'h00, 7, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'h00, 7, 3'd2, 2'b01);
    vectors++;
    if (b_resp !== 2'b00 || b_id !== 1'b0) begin
      miscompares++; $display("FAIL incr_b: bresp=%b bid=%b, want 00/0", b_resp, b_id);
    end
    vectors++;
    if (aw_wait !== 1 || b_wait !== 0) begin
      miscompares++; $display("FAIL incr_wr_latency: aw_wait=%0d b_wait=%0d, want 1/0", aw_wait, b_wait);
    end
    axi_read(8'h00, 7, 3'd2, 2'b01, 1'b0);
    vectors++;
    if (ar_wait !== 1 || r_wait0 !== 0) begin
      miscompares++; $display("FAIL incr_rd_latency: ar_wait=%0d r_wait0=%0d, want 1/0", ar_wait, r_wait0);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rd_dat[i] !== 32'(i + 1) || rd_last[i] !== (i == 7) || rd_resp[i] !== 2'b00 || rd_id[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL incr_beat%0d: data=%h last=%b resp=%b id=%b, want %h/%b/00/0",
                 i, rd_dat[i], rd_last[i], rd_resp[i], rd_id[i], 32'(i + 1), (i == 7));
      end
    end
  endtask

  task automatic test_strobe();
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    axi_write(8'h20, 0, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'h20, 0, 3'd2, 2'b01);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0011;
    axi_write(8'h20, 0, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'h20, 0, 3'd2, 2'b01);
    axi_read(8'h20, 0, 3'd2, 2'b01, 1'b0);
    vectors++;
    if (rd_dat[0] !== 32'h1122CCDD || rd_dat[0] !== model_rd(8'h20, 0, 1'b0)) begin
      miscompares++; $display("FAIL strobe_merge: got %h, want 1122ccdd", rd_dat[0]);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] d [4];
    rand_data(3);
    for (int i = 0; i < 4; i++) d[i] = wdat[i];
    axi_write(8'hF8, 3, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'hF8, 3, 3'd2, 2'b01);
    axi_read(8'hF8, 3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_dat[i] !== d[i]) begin
        miscompares++; $display("FAIL wrap_read_beat%0d: got %h, want %h", i, rd_dat[i], d[i]);
      end
    end
    axi_read(8'h00, 1, 3'd2, 2'b01, 1'b0);
    vectors++;
    if (rd_dat[0] !== d[2] || rd_dat[1] !== d[3]) begin
      miscompares++;
      $display("FAIL wrap_words_0_1: got %h %h, want %h %h", rd_dat[0], rd_dat[1], d[2], d[3]);
    end
  endtask

  task automatic test_arbitration();
    ARESET = 1'b1; tick(); ARESET = 1'b0; tick();
    rand_data(1);
    set_aw(8'h80, 1, 3'd2, 2'b01, 1'b0);
    set_ar(8'h80, 1, 3'd2, 2'b01, 1'b1);
    tick();
    vectors++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_first: awready=%b arready=%b, want 1/0", S_AXI_AWREADY, S_AXI_ARREADY);
    end
    tick();
    S_AXI_AWVALID = 1'b0;
    w_beats(1, -1);
    b_handshake();
    model_write(8'h80, 1, 3'd2, 2'b01);
    set_aw(8'h90, 0, 3'd2, 2'b01, 1'b0);
    tick();
    vectors++;
    if (S_AXI_ARREADY !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_second: arready=%b awready=%b, want 1/0", S_AXI_ARREADY, S_AXI_AWREADY);
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    r_beats(1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rd_dat[i] !== model_rd(8'h80, i, 1'b0) || rd_id[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL arb_read_beat%0d: data=%h id=%b, want %h/1", i, rd_dat[i], rd_id[i], model_rd(8'h80, i, 1'b0));
      end
    end
    rand_data(0);
    aw_handshake();
    w_beats(0, -1);
    b_handshake();
    model_write(8'h90, 0, 3'd2, 2'b01);
    vectors++;
    if (b_resp !== 2'b00) begin miscompares++; $display("FAIL arb_pending_write: bresp=%b, want 00", b_resp); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] held;
    rand_data(3);
    axi_write(8'h40, 3, 3'd2, 2'b01, 1'b0, -1);
    model_write(8'h40, 3, 3'd2, 2'b01);
    set_ar(8'h40, 3, 3'd2, 2'b01, 1'b0);
    ar_handshake();
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!S_AXI_RVALID && n < TMO) begin tick(); n++; end
      if (!S_AXI_RVALID) timeout_fail("stall_rvalid");
      vectors++;
      if (S_AXI_RDATA !== model_rd(8'h40, i, 1'b0) || S_AXI_RLAST !== (i == 3)) begin
        miscompares++;
        $display("FAIL stall_beat%0d: data=%h last=%b, want %h/%b", i, S_AXI_RDATA, S_AXI_RLAST,
                 model_rd(8'h40, i, 1'b0), (i == 3));
      end
      if (i == 1) begin
        held = model_rd(8'h40, 1, 1'b0);
        S_AXI_RREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          vectors++;
          if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== held || S_AXI_RLAST !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: valid=%b data=%h last=%b, want 1/%h/0",
                     k, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, held);
          end
        end
        S_AXI_RREADY = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_wrap_burst_err();
    rand_data(1);
    axi_write(8'h40, 1, 3'd2, 2'b10, 1'b0, -1);
    model_write(8'h40, 1, 3'd2, 2'b10);
    vectors++;
    if (b_resp !== 2'b10) begin miscompares++; $display("FAIL wrap_burst_bresp: got %b, want 10", b_resp); end
    axi_read(8'h40, 1, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rd_dat[i] !== model_rd(8'h40, i, 1'b0)) begin
        miscompares++;
        $display("FAIL wrap_burst_unchanged%0d: got %h, want %h", i, rd_dat[i], model_rd(8'h40, i, 1'b0));
      end
    end
  endtask

  task automatic test_arsize_err();
    axi_read(8'h40, 3, 3'd1, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_dat[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL arsize_beat%0d: data=%h resp=%b last=%b, want 0/10/%b",
                 i, rd_dat[i], rd_resp[i], rd_last[i], (i == 3));
      end
    end
  endtask

  task automatic test_wlast_early();
    rand_data(3);
    axi_write(8'hC0, 3, 3'd2, 2'b01, 1'b0, 1);
    model_write(8'hC0, 3, 3'd2, 2'b01);
    vectors++;
    if (b_resp !== 2'b10) begin miscompares++; $display("FAIL wlast_early_bresp: got %b, want 10", b_resp); end
    axi_read(8'hC0, 3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_dat[i] !== model_rd(8'hC0, i, 1'b0) || rd_resp[i] !== 2'b00) begin
        miscompares++;
        $display("FAIL wlast_early_beat%0d: data=%h resp=%b, want %h/00", i, rd_dat[i], rd_resp[i],
                 model_rd(8'hC0, i, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [7:0] addr;
      logic       err;
      logic [2:0] size;
      int         len;
      addr = 8'($urandom_range(0, 63) * 4);
      len  = $urandom_range(0, 7);
      err  = ($urandom_range(0, 7) == 0);
      size = err ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        axi_write(addr, len, size, 2'b01, 1'($urandom), -1);
        model_write(addr, len, size, 2'b01);
        vectors++;
        if (b_resp !== (err ? 2'b10 : 2'b00)) begin
          miscompares++; $display("FAIL rand%0d_bresp: got %b, want %b", t, b_resp, err ? 2'b10 : 2'b00);
        end
      end else begin
        axi_read(addr, len, size, 2'b01, 1'b0);
        for (int i = 0; i <= len; i++) begin
          vectors++;
          if (rd_dat[i] !== model_rd(addr, i, err) || rd_resp[i] !== (err ? 2'b10 : 2'b00) ||
              rd_last[i] !== (i == len)) begin
            miscompares++;
            $display("FAIL rand%0d_beat%0d: data=%h resp=%b last=%b, want %h/%b/%b", t, i,
                     rd_dat[i], rd_resp[i], rd_last[i], model_rd(addr, i, err), err ? 2'b10 : 2'b00, (i == len));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reset_mid_write();
    test_incr();
    test_strobe();
    test_addr_wrap();
    test_arbitration();
    test_rready_stall();
    test_wrap_burst_err();
    test_arsize_err();
    test_wlast_early();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rete_mnist_axi4_slave_mem.md
# rete_mnist_axi4_slave_mem

AXI4-full burst slave with a 32-bit register-array memory. It answers the bursts issued by the master VIP and by the MNIST DMA/host path on the S_mnist_full_AXI port. It holds input pixels and weights for the network datapath and returns them on read-back. A single FSM serves one burst at a time, write or read, with round-robin arbitration when both request together.

## Interface
- C_S_AXI_ID_WIDTH, 1: width of AWID/BID/ARID/RID.
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 8: byte address width; memory depth is 2^(C_S_AXI_ADDR_WIDTH-2) words (64 words at the default).

Ports:
- ACLK  in  1  clock, all logic on the rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWID/AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]/AWVALID  in  write address channel.
- S_AXI_AWREADY  out  1
- S_AXI_WDATA[32]/WSTRB[4]/WLAST/WVALID  in  write data channel.
- S_AXI_WREADY  out  1
- S_AXI_BID/BRESP[2]/BVALID  out  write response channel.
- S_AXI_BREADY  in  1
- S_AXI_ARID/ARADDR/ARLEN[8]/ARSIZE[3]/ARBURST[2]/ARVALID  in  read address channel.
- S_AXI_ARREADY  out  1
- S_AXI_RID/RDATA[32]/RRESP[2]/RLAST/RVALID  out  read data channel.
- S_AXI_RREADY  in  1
- LOCK/CACHE/PROT/QOS/REGION/USER signals are not ports; the interconnect ties them off.

## Operation
- FSM states: IDLE, AW_ACK, WDATA, WRESP, AR_ACK, RDATA.
- IDLE, only AWVALID=1: go to AW_ACK. Only ARVALID=1: go to AR_ACK.
- IDLE, both valid: pointer `last_wr` selects the winner. After reset the write wins. Afterwards the opposite of the last-served direction wins.
- AW_ACK: AWREADY=1 for exactly one cycle. Latch ID, word index = AWADDR[ADDR_WIDTH-1:2], LEN and error flag (error = AWSIZE≠2 or AWBURST≠INCR). Go to WDATA with beat counter at 0.
- WDATA: WREADY=1.
  - Each WVALID&WREADY beat writes the bytes enabled by WSTRB into mem[index], unless the error flag is set.
  - After each beat, index increments modulo depth (wrap-around) and the counter increments.
  - The burst ends on beat LEN+1, regardless of WLAST.
  - A protocol error is flagged if WLAST=1 before the final beat or WLAST=0 on the final beat. Data is still written.
  - After the final beat go to WRESP.
- WRESP: BVALID=1, BID=latched ID, BRESP=SLVERR(2'b10) if any error flag is set, else OKAY. Hold until BREADY, then go to IDLE and set last_wr=1.
- AR_ACK: ARREADY=1 for one cycle. Latch fields the same way as AW_ACK (error = ARSIZE≠2 or ARBURST≠INCR). Load RDATA with mem[index], or 0 on error. Go to RDATA.
- RDATA: RVALID=1, RID=latched ID, RRESP=SLVERR/OKAY.
  - RLAST=1 only on beat LEN+1.
  - On RVALID&RREADY:
    - Not last: RDATA is loaded with mem[index+1 mod depth] and RVALID stays high.
    - Last: RVALID drops, go to IDLE, set last_wr=0.
- Memory is not reset; its contents survive ARESET.

## Timing
- ARESET asserted, at any time including mid-burst: state=IDLE, last_wr=0, and all outputs are 0 immediately (AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID, RDATA). The aborted burst is dropped with no response.
- All outputs are registered; no combinational path from inputs to outputs.
- AWVALID seen in IDLE at cycle N: AWREADY=1 at N+1, WREADY=1 from N+2.
- Final W beat accepted at cycle M: BVALID=1 at M+1.
- ARVALID seen in IDLE at cycle N: ARREADY=1 at N+1, first RVALID at N+2.
- Read beats run at one per cycle while RREADY=1.
- RREADY=0: RDATA, RLAST, RID and RRESP stay stable.
- BVALID and RVALID, once high, never drop without the handshake.
- The FSM returns to IDLE one cycle after the B or last-R handshake. Minimum turnaround between bursts is 1 idle cycle.
- A write and a read are never active simultaneously.

## Test plan
- Reset mid-WDATA (after 3 of 8 beats) -> all outputs 0 that cycle. A fresh write after reset completes with BRESP=OKAY.
- INCR write: addr 0, LEN=7, data 1..8, WSTRB=F, then read addr 0, LEN=7 -> RDATA 1..8, RLAST only on beat 8, BRESP=RRESP=OKAY, RID=BID=0.
- mem[8] (byte addr 0x20)=0x11223344; single-beat write 0xAABBCCDD, WSTRB=4'b0011 -> read returns 0x1122CCDD.
- Write at addr 0xF8, LEN=3, data A,B,C,D -> words 62,63,0,1 hold A,B,C,D. A 4-beat read at 0xF8 returns A,B,C,D.
- AWVALID and ARVALID raised together after reset -> AWREADY first, read served after BVALID handshake. Second simultaneous request -> ARREADY first.
- RREADY low for 3 cycles after beat 2 -> beat 2 data and RLAST=0 held stable.
- AWBURST=WRAP, LEN=1 -> memory unchanged, BRESP=SLVERR.
- ARSIZE=1 -> RDATA=0 with RRESP=SLVERR on every beat.
- Write with WLAST on beat 2 of 4 -> all 4 beats written, BRESP=SLVERR.
